// File: rtl/sign_mag_enc_pipe.sv
// Two-stage signed-operand encoder: per-lane decode to magnitude + sign in S1,
// registered outputs with negative-lane count in S2, single global stall enable.
module sign_mag_enc_pipe #(
  parameter  int W     = 8,
  parameter  int LANES = 4,
  parameter  int SAT   = 1,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [LANES*W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] mag_out,
  output logic [LANES-1:0]   sign_out,
  output logic [LANES-1:0]   ovf_out,
  output logic [CW-1:0]      neg_cnt
);

  localparam int MW = W - 1;
  localparam logic [MW-1:0] ONE_LOW = {{(MW-1){1'b0}}, 1'b1};
  // Magnitude reported for the most-negative two's-complement value.
  localparam logic [MW-1:0] MIN_MAG = (SAT != 0) ? {MW{1'b1}} : {MW{1'b0}};

  logic en;
  logic accept;

  logic [LANES*MW-1:0] dec_mag;
  logic [LANES-1:0]    dec_sign;
  logic [LANES-1:0]    dec_ovf;

  logic                s1_valid_q, s1_valid_d;
  logic [LANES*MW-1:0] s1_mag_q, s1_mag_d;
  logic [LANES-1:0]    s1_sign_q, s1_sign_d;
  logic [LANES-1:0]    s1_ovf_q, s1_ovf_d;
  logic [CW-1:0]       s1_cnt;

  logic                out_valid_q, out_valid_d;
  logic [LANES*MW-1:0] mag_q, mag_d;
  logic [LANES-1:0]    sign_q, sign_d;
  logic [LANES-1:0]    ovf_q, ovf_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en & ~rst;
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0]  x;
      logic          s;
      logic [MW-1:0] low;
      logic [MW-1:0] neg_low;
      logic          is_min;

      assign x       = data_in[gi*W +: W];
      assign s       = x[W-1];
      assign low     = x[MW-1:0];
      assign neg_low = ~low + ONE_LOW;
      // Pattern 100..0: most-negative in two's complement, negative zero in sign-magnitude.
      assign is_min  = s & (low == {MW{1'b0}});

      assign dec_sign[gi] = in_mode ? (s & ~is_min) : s;
      assign dec_ovf[gi]  = ~in_mode & is_min;
      assign dec_mag[gi*MW +: MW] = in_mode ? low :
                                    is_min  ? MIN_MAG :
                                    s       ? neg_low : low;

      assign mag_out[gi*W +: W] = {1'b0, mag_q[gi*MW +: MW]};
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_sign_d  = s1_sign_q;
    s1_ovf_d   = s1_ovf_q;
    if (en) begin
      s1_valid_d = accept;
      s1_mag_d   = dec_mag;
      s1_sign_d  = dec_sign;
      s1_ovf_d   = dec_ovf;
    end
  end

  always_comb begin
    s1_cnt = {CW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      s1_cnt = s1_cnt + CW'(s1_sign_q[i]);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    mag_d       = mag_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      mag_d       = s1_mag_q;
      sign_d      = s1_sign_q;
      ovf_d       = s1_ovf_q;
      cnt_d       = s1_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_sign_q   <= '0;
      s1_ovf_q    <= '0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      sign_q      <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_q    <= s1_mag_d;
      s1_sign_q   <= s1_sign_d;
      s1_ovf_q    <= s1_ovf_d;
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign_out  = sign_q;
  assign ovf_out   = ovf_q;
  assign neg_cnt   = cnt_q;

endmodule
